// File: rtl/pipeline_trace_tracker.sv
// Follows instructions through a NUM_STAGES-deep pipeline and emits one retire record per instruction
// (tag, issue/retire cycle stamps, accumulated stall cycles) into a first-word-fall-through FIFO.
module pipeline_trace_tracker #(
  parameter int NUM_STAGES = 5,
  parameter int ID_W       = 8,
  parameter int CYC_W      = 32,
  parameter int STALL_W    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [NUM_STAGES-1:0]         stall,
  input  logic [NUM_STAGES-1:0]         flush,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [ID_W-1:0]               rec_id,
  output logic [CYC_W-1:0]              rec_issue_cycle,
  output logic [CYC_W-1:0]              rec_retire_cycle,
  output logic [STALL_W-1:0]            rec_stall_cnt,
  output logic [CYC_W-1:0]              cycle_cnt,
  output logic [CYC_W-1:0]              retired_cnt,
  output logic [CYC_W-1:0]              flushed_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic [ID_W-1:0]    tag;
    logic [CYC_W-1:0]   iss;
    logic [CYC_W-1:0]   ret;
    logic [STALL_W-1:0] stl;
  } rec_t;

  logic [NUM_STAGES-1:0]              hold, kill;
  logic [NUM_STAGES-1:0]              vld_q;
  logic [NUM_STAGES-1:0][ID_W-1:0]    tag_q;
  logic [NUM_STAGES-1:0][CYC_W-1:0]   iss_q;
  logic [NUM_STAGES-1:0][STALL_W-1:0] stl_q;

  logic [CYC_W-1:0] cycle_q, cycle_d, retired_q, retired_d, flushed_q, flushed_d;
  logic [ID_W-1:0]  next_id_q, next_id_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             retire, push, pop, full;
  logic [FCW-1:0]   flush_n;
  logic [CYC_W:0]   flushed_sum;
  rec_t             mem_q [FIFO_DEPTH];

  // A stage holds when it or any younger-facing downstream stage stalls; a flush
  // bit kills its own stage and everything upstream of it.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic               v_q, v_d;
    logic [ID_W-1:0]    t_q, t_d;
    logic [CYC_W-1:0]   i_q, i_d;
    logic [STALL_W-1:0] s_q, s_d, s_inc;

    assign hold[gi]  = |stall[NUM_STAGES-1:gi];
    assign kill[gi]  = |flush[NUM_STAGES-1:gi];
    assign s_inc     = (s_q == '1) ? s_q : s_q + 1'b1;
    assign vld_q[gi] = v_q;
    assign tag_q[gi] = t_q;
    assign iss_q[gi] = i_q;
    assign stl_q[gi] = s_q;

    if (gi == 0) begin : g_head
      always_comb begin
        v_d = v_q;
        t_d = t_q;
        i_d = i_q;
        s_d = s_q;
        if (!hold[0]) begin
          v_d = issue_valid;
          t_d = next_id_q;
          i_d = cycle_q;
          s_d = '0;
        end else if (kill[0]) begin
          v_d = 1'b0;
        end else if (v_q) begin
          s_d = s_inc;
        end
      end
    end else begin : g_body
      always_comb begin
        v_d = v_q;
        t_d = t_q;
        i_d = i_q;
        s_d = s_q;
        if (kill[gi]) begin
          v_d = 1'b0;
        end else if (hold[gi]) begin
          if (v_q) s_d = s_inc;
        end else begin
          v_d = vld_q[gi-1] && !hold[gi-1] && !kill[gi-1];
          t_d = tag_q[gi-1];
          i_d = iss_q[gi-1];
          s_d = stl_q[gi-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        t_q <= '0;
        i_q <= '0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        t_q <= t_d;
        i_q <= i_d;
        s_q <= s_d;
      end
    end
  end

  always_comb begin
    flush_n = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (vld_q[s] && kill[s]) flush_n = flush_n + FCW'(1);
    end
  end

  assign retire      = vld_q[NUM_STAGES-1] && !kill[NUM_STAGES-1] && !hold[NUM_STAGES-1];
  assign full        = (cnt_q == CW'(FIFO_DEPTH));
  assign pop         = (cnt_q != '0) && rec_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push        = retire && (!full || pop);
  assign flushed_sum = {1'b0, flushed_q} + (CYC_W+1)'(flush_n);

  always_comb begin
    cycle_d    = cycle_q + 1'b1;
    next_id_d  = (issue_valid && !hold[0]) ? next_id_q + 1'b1 : next_id_q;
    retired_d  = (retire && retired_q != '1) ? retired_q + 1'b1 : retired_q;
    flushed_d  = flushed_sum[CYC_W] ? '1 : flushed_sum[CYC_W-1:0];
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (retire && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= '0;
      next_id_q  <= '0;
      retired_q  <= '0;
      flushed_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      next_id_q  <= next_id_d;
      retired_q  <= retired_d;
      flushed_q  <= flushed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{tag: tag_q[NUM_STAGES-1], iss: iss_q[NUM_STAGES-1],
                           ret: cycle_q, stl: stl_q[NUM_STAGES-1]};
    end
  end

  assign issue_ready      = !hold[0];
  assign rec_valid        = (cnt_q != '0);
  assign rec_id           = mem_q[rd_ptr_q].tag;
  assign rec_issue_cycle  = mem_q[rd_ptr_q].iss;
  assign rec_retire_cycle = mem_q[rd_ptr_q].ret;
  assign rec_stall_cnt    = mem_q[rd_ptr_q].stl;
  assign cycle_cnt        = cycle_q;
  assign retired_cnt      = retired_q;
  assign flushed_cnt      = flushed_q;
  assign fifo_count       = cnt_q;
  assign overflow         = overflow_q;

endmodule

// File: doc/pipeline_trace_tracker.md
PIPELINE_TRACE_TRACKER -- requirements
Module: pipeline_trace_tracker

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of tracked pipeline stages (min 2).
REQ-002 SHALL have parameter ID_W, default 8, instruction tag width.
REQ-003 SHALL have parameter CYC_W, default 32, cycle counter and stamp width.
REQ-004 SHALL have parameter STALL_W, default 8, per-instruction stall counter width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, retire record FIFO entries (power of two, min 2).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 issue_valid  in  1  new instruction enters stage 0.
REQ-009 issue_ready  out  1  stage 0 can accept this cycle.
REQ-010 stall  in  NUM_STAGES  per-stage stall request.
REQ-011 flush  in  NUM_STAGES  per-stage flush request.
REQ-012 rec_valid  out  1  retire record available.
REQ-013 rec_ready  in  1  consumer accepts record.
REQ-014 rec_id  out  ID_W  tag of head record.
REQ-015 rec_issue_cycle, rec_retire_cycle  out  CYC_W each  stamps of head record.
REQ-016 rec_stall_cnt  out  STALL_W  stall cycles of head record.
REQ-017 cycle_cnt  out  CYC_W  free-running cycle counter.
REQ-018 retired_cnt, flushed_cnt  out  CYC_W each  event counters.
REQ-019 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-020 overflow  out  1  sticky record-drop flag.

Function
REQ-021 cycle_cnt SHALL increment by 1 every non-reset cycle, wrapping modulo 2^CYC_W.
REQ-022 hold[s] SHALL equal OR of stall[s..NUM_STAGES-1]; issue_ready SHALL equal !hold[0].
REQ-023 Per stage s: valid bit, tag, issue stamp, stall counter.
REQ-024 If hold[s]: stage s keeps contents; stall counter of a valid occupant increments, saturating at 2^STALL_W-1.
REQ-025 If !hold[s] and s>0: stage s loads stage s-1 contents, or a bubble when hold[s-1] is set.
REQ-026 If !hold[0]: stage 0 loads a new entry when issue_valid (tag=next_id, issue stamp=current cycle_cnt, stall=0), else a bubble; next_id increments on acceptance, wrapping modulo 2^ID_W.
REQ-027 flush[s] SHALL discard every entry present in stages 0..s this cycle; flush takes precedence over stall and hold; highest asserted flush bit defines the range; stage s+1 receives a bubble.
REQ-028 A new issue in the same cycle as any flush SHALL still be accepted into stage 0 when issue_ready.
REQ-029 flushed_cnt SHALL add the count of valid entries discarded, saturating.
REQ-030 Retire: valid, unflushed entry in stage NUM_STAGES-1 with !hold[NUM_STAGES-1] SHALL push {tag, issue stamp, cycle_cnt, stall counter} and increment retired_cnt (saturating), including dropped records.
REQ-031 Without stalls, issue accepted in cycle t SHALL yield rec_retire_cycle = t+NUM_STAGES and rec_valid in cycle t+NUM_STAGES+1.
REQ-032 FIFO first-word-fall-through; rec_valid = fifo_count!=0; pop on rec_valid && rec_ready.
REQ-033 Push when full with simultaneous pop SHALL succeed; push when full without pop SHALL drop the record and set overflow.
REQ-034 overflow SHALL remain set until reset.

Reset
REQ-035 rst SHALL clear all stage valid bits, next_id, cycle_cnt, retired_cnt, flushed_cnt, fifo_count and overflow to 0; rec_valid=0; issue_ready=1 after reset.
REQ-036 rst mid-operation SHALL discard all in-flight entries and FIFO records without counting them as flushed or retired.

Verification
REQ-037 Reset, issue_valid=1 one cycle at cycle_cnt=3 -> record id=0, issue=3, retire=8, stall_cnt=0, retired_cnt=1.
REQ-038 id0 in stage 2, stall[2]=1 for 2 cycles -> issue_ready=0 those cycles, id0 stall_cnt=2, retire-issue=7, id1 in stage 1 stall_cnt=2.
REQ-039 ids 0,1,2 in stages 2,1,0, flush[1]=1 -> ids 1,2 discarded, flushed_cnt=2, id0 retires, next issue gets id 3.
REQ-040 FIFO_DEPTH=2, rec_ready=0, 3 back-to-back issues -> fifo_count=2, overflow=1, retired_cnt=3; then full push with rec_ready=1 -> no drop, count stays 2.
REQ-041 ID_W=2, 5 issues -> rec_id sequence 0,1,2,3,0.
REQ-042 rst asserted with 3 in-flight entries and 1 FIFO record -> next cycle rec_valid=0, all counters 0, overflow=0, next issue id=0.
